// File: rtl/decode_stage.sv
// ID stage of the WISC pipeline: field decode, 8x16 register file, load-use hazard detection, ID/EX register.
// Optional REGFILE_BYPASS_EN: same-cycle write-before-read forwarding instead of a one-cycle writeback stall.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_IFID,
  input  logic [15:0] PC2_IFID,
  input  logic        halt_IFID,
  input  logic        freeze,
  input  logic        takeBranch_EXMEM,
  input  logic        wbEn,
  input  logic [2:0]  wbReg,
  input  logic [15:0] wbData,
  output logic        stallCtrl,
  output logic [15:0] rsData_IDEX,
  output logic [15:0] rtData_IDEX,
  output logic [15:0] imm_IDEX,
  output logic [2:0]  rd_IDEX,
  output logic [4:0]  opcode_IDEX,
  output logic        regWrite_IDEX,
  output logic        memRead_IDEX,
  output logic        memWrite_IDEX,
  output logic [15:0] PC2_IDEX,
  output logic        halt_IDEX
);

  localparam int NUM_REGS = 8;

  logic [15:0] regs [NUM_REGS];

  logic [4:0]  op;
  logic [2:0]  rs, rt, rd;
  logic        is_r, is_i1, is_store, uses_rt;
  logic        reg_write, mem_read, mem_write;
  logic [15:0] imm, rs_data, rt_data;
  logic        ld_haz, wb_haz;

  assign op = instr_IFID[15:11];
  assign rs = instr_IFID[10:8];
  assign rt = instr_IFID[7:5];

  assign is_r     = (op == 5'b11011) || (op == 5'b11010) || (op[4:2] == 3'b111);
  assign is_i1    = (op[4:2] == 3'b010) || (op[4:2] == 3'b101) || (op == 5'b10001);
  assign is_store = (op == 5'b10000) || (op == 5'b10011);
  assign uses_rt  = is_r || is_store;
  assign mem_read  = (op == 5'b10001);
  assign mem_write = is_store;
  assign reg_write = !((op == 5'b00000) || (op == 5'b00001) || (op == 5'b10000) ||
                       (op[4:2] == 3'b011) || (op == 5'b00100) || (op == 5'b00101));

  always_comb begin
    rd = rt;
    if (is_r)                                    rd = instr_IFID[4:2];
    else if (is_i1)                              rd = rt;
    else if ((op == 5'b11000) || (op == 5'b10010)) rd = rs;
    else if ((op == 5'b00110) || (op == 5'b00111)) rd = 3'd7;
  end

  always_comb begin
    if ((op == 5'b00100) || (op == 5'b00110))
      imm = {{5{instr_IFID[10]}}, instr_IFID[10:0]};
    else if ((op == 5'b11000) || (op == 5'b10010) || (op[4:2] == 3'b011) ||
             (op == 5'b00101) || (op == 5'b00111))
      imm = {{8{instr_IFID[7]}}, instr_IFID[7:0]};
    else if ((op == 5'b01010) || (op == 5'b01011))
      imm = {11'b0, instr_IFID[4:0]};
    else
      imm = {{11{instr_IFID[4]}}, instr_IFID[4:0]};
  end

`ifdef REGFILE_BYPASS_EN
  assign rs_data = (wbEn && (wbReg == rs)) ? wbData : regs[rs];
  assign rt_data = (wbEn && (wbReg == rt)) ? wbData : regs[rt];
  assign wb_haz  = 1'b0;
`else
  // Without forwarding, a read colliding with a writeback waits one cycle for the write to land.
  assign rs_data = regs[rs];
  assign rt_data = regs[rt];
  assign wb_haz  = wbEn && ((wbReg == rs) || (uses_rt && (wbReg == rt)));
`endif

  assign ld_haz = memRead_IDEX && regWrite_IDEX &&
                  ((rd_IDEX == rs) || (uses_rt && (rd_IDEX == rt)));
  assign stallCtrl = (ld_haz || wb_haz) && !takeBranch_EXMEM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      regs <= '{default: '0};
    else if (wbEn) regs[wbReg] <= wbData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsData_IDEX   <= '0;
      rtData_IDEX   <= '0;
      imm_IDEX      <= '0;
      rd_IDEX       <= '0;
      opcode_IDEX   <= 5'b00001;
      regWrite_IDEX <= 1'b0;
      memRead_IDEX  <= 1'b0;
      memWrite_IDEX <= 1'b0;
      PC2_IDEX      <= '0;
      halt_IDEX     <= 1'b0;
    end else if (freeze) begin
      // Flush and load-use stall both insert the same bubble; flush already masks stallCtrl.
      if (takeBranch_EXMEM || stallCtrl) begin
        rsData_IDEX   <= '0;
        rtData_IDEX   <= '0;
        imm_IDEX      <= '0;
        rd_IDEX       <= '0;
        opcode_IDEX   <= 5'b00001;
        regWrite_IDEX <= 1'b0;
        memRead_IDEX  <= 1'b0;
        memWrite_IDEX <= 1'b0;
        PC2_IDEX      <= '0;
        halt_IDEX     <= 1'b0;
      end else begin
        rsData_IDEX   <= rs_data;
        rtData_IDEX   <= rt_data;
        imm_IDEX      <= imm;
        rd_IDEX       <= rd;
        opcode_IDEX   <= op;
        regWrite_IDEX <= reg_write;
        memRead_IDEX  <= mem_read;
        memWrite_IDEX <= mem_write;
        PC2_IDEX      <= PC2_IFID;
        halt_IDEX     <= halt_IFID;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table via scoreboard queue plus hazard/freeze/reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_IFID, PC2_IFID, wbData;
  logic        halt_IFID, freeze, takeBranch_EXMEM, wbEn;
  logic [2:0]  wbReg;
  logic        stallCtrl;
  logic [15:0] rsData_IDEX, rtData_IDEX, imm_IDEX, PC2_IDEX;
  logic [2:0]  rd_IDEX;
  logic [4:0]  opcode_IDEX;
  logic        regWrite_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .PC2_IFID(PC2_IFID),
    .halt_IFID(halt_IFID), .freeze(freeze), .takeBranch_EXMEM(takeBranch_EXMEM),
    .wbEn(wbEn), .wbReg(wbReg), .wbData(wbData), .stallCtrl(stallCtrl),
    .rsData_IDEX(rsData_IDEX), .rtData_IDEX(rtData_IDEX), .imm_IDEX(imm_IDEX),
    .rd_IDEX(rd_IDEX), .opcode_IDEX(opcode_IDEX), .regWrite_IDEX(regWrite_IDEX),
    .memRead_IDEX(memRead_IDEX), .memWrite_IDEX(memWrite_IDEX),
    .PC2_IDEX(PC2_IDEX), .halt_IDEX(halt_IDEX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        halt;
    logic [4:0]  op;
    logic [2:0]  rd;
    logic        rd_chk;
    logic [15:0] imm, rsd, rtd;
    logic        rw, mr, mw;
    logic [15:0] pc2;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];
  vec_t sbq [$];
  vec_t v, e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_op"},   16'(opcode_IDEX), 16'h0001);
    chk({tag, "_rw"},   16'(regWrite_IDEX), 16'h0);
    chk({tag, "_mr"},   16'(memRead_IDEX), 16'h0);
    chk({tag, "_mw"},   16'(memWrite_IDEX), 16'h0);
    chk({tag, "_halt"}, 16'(halt_IDEX), 16'h0);
    chk({tag, "_rs"},   rsData_IDEX, 16'h0);
  endtask

  function automatic logic [15:0] rv(input int unsigned i);
    return 16'hA000 | 16'(i * 16'h0111);
  endfunction

  initial begin
    //          instr     halt  op        rd    chk   imm       rsd       rtd       rw    mr    mw    pc2
    vec[0]  = '{16'hDB64, 1'b0, 5'b11011, 3'd1, 1'b1, 16'h0004, 16'hA333, 16'hA333, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[1]  = '{16'hE5DC, 1'b0, 5'b11100, 3'd7, 1'b1, 16'hFFFC, 16'hA555, 16'hA666, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[2]  = '{16'h415F, 1'b0, 5'b01000, 3'd2, 1'b1, 16'hFFFF, 16'hA111, 16'hA222, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[3]  = '{16'h547F, 1'b0, 5'b01010, 3'd3, 1'b1, 16'h001F, 16'hA444, 16'hA333, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[4]  = '{16'h86B0, 1'b0, 5'b10000, 3'd0, 1'b0, 16'hFFF0, 16'hA666, 16'hA555, 1'b0, 1'b0, 1'b1, 16'h0};
    vec[5]  = '{16'hC780, 1'b0, 5'b11000, 3'd7, 1'b1, 16'hFF80, 16'hA777, 16'hA444, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[6]  = '{16'h907F, 1'b0, 5'b10010, 3'd0, 1'b1, 16'h007F, 16'hA000, 16'hA333, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[7]  = '{16'h62FE, 1'b0, 5'b01100, 3'd0, 1'b0, 16'hFFFE, 16'hA222, 16'hA777, 1'b0, 1'b0, 1'b0, 16'h0};
    vec[8]  = '{16'h2400, 1'b0, 5'b00100, 3'd0, 1'b0, 16'hFC00, 16'hA444, 16'hA000, 1'b0, 1'b0, 1'b0, 16'h0};
    vec[9]  = '{16'h33FF, 1'b0, 5'b00110, 3'd7, 1'b1, 16'h03FF, 16'hA333, 16'hA777, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[10] = '{16'h3905, 1'b0, 5'b00111, 3'd7, 1'b1, 16'h0005, 16'hA111, 16'hA000, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[11] = '{16'h2BFD, 1'b0, 5'b00101, 3'd0, 1'b0, 16'hFFFD, 16'hA333, 16'hA777, 1'b0, 1'b0, 1'b0, 16'h0};
    vec[12] = '{16'h0800, 1'b0, 5'b00001, 3'd0, 1'b0, 16'h0000, 16'hA000, 16'hA000, 1'b0, 1'b0, 1'b0, 16'h0};
    vec[13] = '{16'h0000, 1'b1, 5'b00000, 3'd0, 1'b0, 16'h0000, 16'hA000, 16'hA000, 1'b0, 1'b0, 1'b0, 16'h0};
    vec[14] = '{16'hA143, 1'b0, 5'b10100, 3'd2, 1'b1, 16'h0003, 16'hA111, 16'hA222, 1'b1, 1'b0, 1'b0, 16'h0};
    vec[15] = '{16'h8C40, 1'b0, 5'b10001, 3'd2, 1'b1, 16'h0000, 16'hA444, 16'hA222, 1'b1, 1'b1, 1'b0, 16'h0};

    // Reset state
    rst = 1'b0; instr_IFID = 16'h0800; PC2_IFID = 16'h0; halt_IFID = 1'b0;
    freeze = 1'b1; takeBranch_EXMEM = 1'b0; wbEn = 1'b0; wbReg = 3'd0; wbData = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op", 16'(opcode_IDEX), 16'h0001);
    chk("rst_rs", rsData_IDEX, 16'h0);
    chk("rst_rt", rtData_IDEX, 16'h0);
    chk("rst_imm", imm_IDEX, 16'h0);
    chk("rst_rd", 16'(rd_IDEX), 16'h0);
    chk("rst_ctl", 16'({regWrite_IDEX, memRead_IDEX, memWrite_IDEX, halt_IDEX}), 16'h0);
    chk("rst_pc2", PC2_IDEX, 16'h0);
    chk("rst_stall", 16'(stallCtrl), 16'h0);
    rst = 1'b1;
    instr_IFID = 16'hDB64;
    step();
    chk("rst_rf_rs", rsData_IDEX, 16'h0);
    chk("rst_rf_rt", rtData_IDEX, 16'h0);

    // Preload R0..R7 with distinct values
    instr_IFID = 16'h0800;
    for (int i = 0; i < 8; i++) begin
      wbEn = 1'b1; wbReg = 3'(i); wbData = rv(i);
      step();
    end
    wbEn = 1'b0;

    // Decode table through scoreboard
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      v.pc2 = 16'h0100 + 16'(2 * i);
      instr_IFID = v.instr; halt_IFID = v.halt; PC2_IFID = v.pc2;
      sbq.push_back(v);
      #1;
      chk($sformatf("tbl%0d_stall", i), 16'(stallCtrl), 16'h0);
      step();
      e = sbq.pop_front();
      chk($sformatf("tbl%0d_op", i), 16'(opcode_IDEX), 16'(e.op));
      if (e.rd_chk) chk($sformatf("tbl%0d_rd", i), 16'(rd_IDEX), 16'(e.rd));
      chk($sformatf("tbl%0d_imm", i), imm_IDEX, e.imm);
      chk($sformatf("tbl%0d_rs", i), rsData_IDEX, e.rsd);
      chk($sformatf("tbl%0d_rt", i), rtData_IDEX, e.rtd);
      chk($sformatf("tbl%0d_rw", i), 16'(regWrite_IDEX), 16'(e.rw));
      chk($sformatf("tbl%0d_mr", i), 16'(memRead_IDEX), 16'(e.mr));
      chk($sformatf("tbl%0d_mw", i), 16'(memWrite_IDEX), 16'(e.mw));
      chk($sformatf("tbl%0d_pc2", i), PC2_IDEX, e.pc2);
      chk($sformatf("tbl%0d_halt", i), 16'(halt_IDEX), 16'(e.halt));
    end
    halt_IFID = 1'b0;
    chk("sb_empty", 16'(sbq.size()), 16'h0);

    // Write R3 then ADD R1,R3,R3
    instr_IFID = 16'h0800; wbEn = 1'b1; wbReg = 3'd3; wbData = 16'h1234;
    step();
    wbEn = 1'b0; instr_IFID = 16'hDB64;
    step();
    chk("add_rs", rsData_IDEX, 16'h1234);
    chk("add_rt", rtData_IDEX, 16'h1234);
    chk("add_rd", 16'(rd_IDEX), 16'h1);
    chk("add_rw", 16'(regWrite_IDEX), 16'h1);

    // Load-use stall: LD R2 then ADD R5,R2,R0
    instr_IFID = 16'h8C40;
    step();
    instr_IFID = 16'hDA14;
    #1;
    chk("lu_stall", 16'(stallCtrl), 16'h1);
    step();
    chk_bubble("lu_bub");
    chk("lu_stall_clr", 16'(stallCtrl), 16'h0);
    step();
    chk("lu_op", 16'(opcode_IDEX), 16'h001B);
    chk("lu_rd", 16'(rd_IDEX), 16'h5);
    chk("lu_rs", rsData_IDEX, 16'hA222);
    chk("lu_rt", rtData_IDEX, 16'hA000);

    // Load-use plus flush: flush wins
    instr_IFID = 16'h8C40;
    step();
    instr_IFID = 16'hDA14; takeBranch_EXMEM = 1'b1; halt_IFID = 1'b1;
    #1;
    chk("fl_stall", 16'(stallCtrl), 16'h0);
    step();
    chk_bubble("fl_bub");
    takeBranch_EXMEM = 1'b0; halt_IFID = 1'b0;

    // Freeze holds ID/EX while writeback still lands
    instr_IFID = 16'h547F; PC2_IFID = 16'h0200;
    step();
    freeze = 1'b0; instr_IFID = 16'hE5DC; PC2_IFID = 16'h0300;
    wbEn = 1'b1; wbReg = 3'd6; wbData = 16'hC0DE;
    for (int c = 0; c < 3; c++) begin
      step();
      wbEn = 1'b0;
      chk($sformatf("frz%0d_op", c), 16'(opcode_IDEX), 16'h000A);
      chk($sformatf("frz%0d_rd", c), 16'(rd_IDEX), 16'h3);
      chk($sformatf("frz%0d_imm", c), imm_IDEX, 16'h001F);
      chk($sformatf("frz%0d_rs", c), rsData_IDEX, 16'hA444);
      chk($sformatf("frz%0d_pc2", c), PC2_IDEX, 16'h0200);
    end
    freeze = 1'b1;
    step();
    chk("frz_rel_op", 16'(opcode_IDEX), 16'h001C);
    chk("frz_rel_rs", rsData_IDEX, 16'hA555);
    chk("frz_rel_rt", rtData_IDEX, 16'hC0DE);
    chk("frz_rel_pc2", PC2_IDEX, 16'h0300);

    // Same-cycle write and read of R4
    instr_IFID = 16'h4420; wbEn = 1'b1; wbReg = 3'd4; wbData = 16'hBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_stall", 16'(stallCtrl), 16'h0);
    step();
    wbEn = 1'b0;
`else
    chk("wb_stall", 16'(stallCtrl), 16'h1);
    step();
    wbEn = 1'b0;
    chk_bubble("wb_bub");
    #1;
    chk("wb_stall_clr", 16'(stallCtrl), 16'h0);
    step();
`endif
    chk("wr_op", 16'(opcode_IDEX), 16'h0008);
    chk("wr_rs", rsData_IDEX, 16'hBEEF);

    // Mid-operation reset discards pending stall and clears regfile
    instr_IFID = 16'h8C40;
    step();
    instr_IFID = 16'hDA14;
    #1;
    chk("mr_stall_pre", 16'(stallCtrl), 16'h1);
    rst = 1'b0;
    #1;
    chk("mr_stall", 16'(stallCtrl), 16'h0);
    chk("mr_op", 16'(opcode_IDEX), 16'h0001);
    chk("mr_mr", 16'(memRead_IDEX), 16'h0);
    #2;
    rst = 1'b1;
    instr_IFID = 16'hDB64;
    step();
    chk("mr_rf_op", 16'(opcode_IDEX), 16'h001B);
    chk("mr_rf_rs", rsData_IDEX, 16'h0);
    chk("mr_rf_rt", rtData_IDEX, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
